datapath_legv8_pipe: RTL
========================

Name: datapath_legv8_pipe

Overview:
Parametrised two-stage successor to the single-cycle LEGv8 datapath. It takes a decoded control word and a constant each cycle.
- Stage E (execute): register read with forwarding, then ALU.
- Stage M (memory/write-back): data-memory access, then register write-back.
The internal tri-state data bus is replaced by an explicit write-back mux. Adds registered NZVC flags, a hardwired zero register, and a pipeline hold input. Sits between the control unit and the top-level CPU.

Parameters:
DATA_WIDTH, 64, datapath and register width (>=8, power of two)
REG_COUNT, 32, architectural registers (power of two); register REG_COUNT-1 is XZR
MEM_DEPTH, 256, data-memory words (power of two)
RA_W (derived), log2(REG_COUNT), register address width
CW_WIDTH (derived), 3*RA_W+10, control word width (25 at defaults)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
cw  in  CW_WIDTH  control word {SA, SB, DA, RegWrite, MemWrite, FS[4:0], Bsel, WBsel, SetFlags}, MSB first
cw_valid  in  1  cw/constant hold a valid operation this cycle
constant  in  DATA_WIDTH  immediate, used as operand B when Bsel=1
hold  in  1  freeze entire pipeline this cycle
status  out  4  registered flags {V, C, N, Z}
wb_valid  out  1  stage M holds a valid operation
wb_reg  out  RA_W  stage-M destination register
wb_data  out  DATA_WIDTH  stage-M write-back value (memory data if WBsel=1, else ALU result)

Behaviour:
- Reset (asynchronous, active-high), all cleared: stage-M registers = 0; wb_valid=0; status=4'b0000; all registers = 0. Data memory is not reset.
- Stage E (combinational):
  - A = reg[SA], B_reg = reg[SB].
  - Forwarding: if wb_valid && M.RegWrite && M.DA==operand address && address!=XZR, the operand takes wb_data.
  - Reads of XZR always return 0.
  - Operand B = Bsel ? constant : B_reg.
- ALU, selected by FS[4:2]: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL A by B[log2(DATA_WIDTH)-1:0], 101 LSR (same amount), 110/111 result 0.
  - FS[1] inverts A before the op.
  - FS[0] inverts B and sets adder carry-in=1, so SUB = 01001.
- Flags: N=result MSB; Z=(result==0); C=adder carry-out for ADD, else 0; V=signed overflow for ADD, else 0.
- Capture edge (cw_valid && !hold):
  - Stage-M registers take ALU result, forwarded B_reg (store data), DA, RegWrite, MemWrite and WBsel.
  - wb_valid<=1.
  - If SetFlags, status<=new flags.
- If !cw_valid && !hold: wb_valid<=0 (bubble); status unchanged.
- Stage M:
  - Memory is word-addressed by ALU result[log2(MEM_DEPTH)-1:0]; upper bits are ignored.
  - Read is combinational. wb_data = WBsel ? mem[addr] : alu_result.
- At the edge ending stage M, when wb_valid && !hold:
  - If MemWrite: mem[addr] <= store data.
  - If RegWrite && DA!=XZR: reg[DA] <= wb_data.
  - Writes to XZR are discarded.
- Latency: one cycle from cw to wb_*. Back-to-back dependent operations need no stall.
- hold=1: no state changes at all (stage-M registers, memory, registers and status all frozen). Outputs stay stable while hold=1.
- Simultaneous MemWrite and WBsel in one operation: wb_data returns the pre-write memory contents.
- Register read/write of the same register in the same cycle: forwarding supplies the new value.
- Reset asserted mid-operation: the in-flight stage-M operation is dropped; no memory or register write occurs.

Decomposition:
- Shared package dp_legv8_pkg holds:
  - FS opcode constants (FS_AND, FS_OR, FS_ADD, FS_SUB, FS_XOR, FS_LSL, FS_LSR);
  - control-word field offsets as functions of RA_W;
  - the stage-M register struct.
- One sub-module: regfile_legv8_param (REG_COUNT x DATA_WIDTH).
  - Two combinational read ports, one write port.
  - XZR hardwired to zero; asynchronous reset clears all entries.
- The ALU is kept inline.

Test Plan:
- Immediate add then dependent op:
  - cw ADD X1=XZR+5 (Bsel=1, constant=5), then next cycle ADD X2=X1+X1 -> wb_data 5, then 10 (forwarding works).
- SUB with SetFlags:
  - X1=3, X2=5, SUB X3=X1-X2 -> wb_data=0xFFFF_FFFF_FFFF_FFFE, status {V,C,N,Z}=0010.
  - Then SUB X4=X2-X2 -> status=0101.
- Store then load:
  - X5=0x1234, MemWrite addr=XZR+8, then load X6 (WBsel=1) addr 8 -> wb_data=0x1234, reg X6=0x1234.
  - Address 8+MEM_DEPTH aliases to 8.
- XZR write:
  - ADD XZR=XZR+7 -> wb_data=7; subsequent read of XZR as operand returns 0, not forwarded 7.
- Hold mid-stream:
  - hold=1 for 3 cycles with store pending -> memory, status, wb_* unchanged.
  - Release -> store commits exactly once.
- Async reset between edges:
  - Pending RegWrite X7=9 -> status=0, wb_valid=0 immediately, X7 reads 0 afterwards.

Source files
------------

// File: rtl/dp_legv8_pkg.sv
// Shared definitions for the two-stage LEGv8 datapath.
// Holds the FS opcode constants, the control-word field offsets
// (functions of the register address width), and the stage-M control
// struct shared by the datapath and its bench.
package dp_legv8_pkg;

  // ALU operation class, carried in FS[4:2]
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_LSL = 3'b100;
  localparam logic [2:0] ALU_LSR = 3'b101;

  // Full FS codes; FS[1] inverts A, FS[0] inverts B with carry-in 1
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  // Control word {SA, SB, DA, RegWrite, MemWrite, FS[4:0], Bsel, WBsel, SetFlags}
  localparam int CW_SETFLAGS = 0;
  localparam int CW_WBSEL    = 1;
  localparam int CW_BSEL     = 2;
  localparam int CW_FS_LSB   = 3;
  localparam int CW_MEMWRITE = 8;
  localparam int CW_REGWRITE = 9;
  localparam int CW_DA_LSB   = 10;

  function automatic int cw_sb_lsb(input int ra_w);
    return 10 + ra_w;
  endfunction

  function automatic int cw_sa_lsb(input int ra_w);
    return 10 + 2 * ra_w;
  endfunction

  // Control bits that travel with an operation into stage M
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic wb_sel;
  } m_ctrl_t;

endpackage

// File: rtl/regfile_legv8_param.sv
// LEGv8 register file: REG_COUNT x DATA_WIDTH, two combinational read
// ports, one synchronous write port. The last register (XZR) always
// reads as zero and ignores writes. Asynchronous reset clears all entries.
// Ports: clock, reset, ra_a/ra_b read addresses, rd_a/rd_b read data,
//        we/wa/wd write enable, address and data.
module regfile_legv8_param #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_COUNT  = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [$clog2(REG_COUNT)-1:0]  ra_a,
  input  logic [$clog2(REG_COUNT)-1:0]  ra_b,
  output logic [DATA_WIDTH-1:0]         rd_a,
  output logic [DATA_WIDTH-1:0]         rd_b,
  input  logic                          we,
  input  logic [$clog2(REG_COUNT)-1:0]  wa,
  input  logic [DATA_WIDTH-1:0]         wd
);

  localparam int RA_W = $clog2(REG_COUNT);
  localparam logic [RA_W-1:0] XZR = RA_W'(REG_COUNT - 1);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  // Register storage: cleared on reset, written unless the target is XZR
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != XZR)) begin
      regs[wa] <= wd;
    end
  end

  // Read ports: XZR is hardwired to zero
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (ra_a == XZR) rd_a = '0;
    else             rd_a = regs[ra_a];
    if (ra_b == XZR) rd_b = '0;
    else             rd_b = regs[ra_b];
  end

endmodule

// File: rtl/datapath_legv8_pipe.sv
// Two-stage LEGv8 datapath. Stage E reads registers (with forwarding from
// stage M) and runs the ALU; stage M accesses data memory and writes back.
// Ports: clock, reset (async, active-high); cw control word, cw_valid,
//        constant immediate, hold freezes everything; status {V,C,N,Z},
//        wb_valid / wb_reg / wb_data describe the operation in stage M.
module datapath_legv8_pipe
  import dp_legv8_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int REG_COUNT  = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [3*$clog2(REG_COUNT)+9:0]     cw,
  input  logic                               cw_valid,
  input  logic [DATA_WIDTH-1:0]              constant,
  input  logic                               hold,
  output logic [3:0]                         status,
  output logic                               wb_valid,
  output logic [$clog2(REG_COUNT)-1:0]       wb_reg,
  output logic [DATA_WIDTH-1:0]              wb_data
);

  localparam int RA_W = $clog2(REG_COUNT);
  localparam int SH_W = $clog2(DATA_WIDTH);
  localparam int MA_W = $clog2(MEM_DEPTH);
  localparam logic [RA_W-1:0] XZR = RA_W'(REG_COUNT - 1);

  // Control word fields
  logic [RA_W-1:0] sa, sb, da;
  logic [4:0]      fs;
  logic            reg_write, mem_write, b_sel, wb_sel, set_flags;

  assign sa        = cw[cw_sa_lsb(RA_W) +: RA_W];
  assign sb        = cw[cw_sb_lsb(RA_W) +: RA_W];
  assign da        = cw[CW_DA_LSB +: RA_W];
  assign reg_write = cw[CW_REGWRITE];
  assign mem_write = cw[CW_MEMWRITE];
  assign fs        = cw[CW_FS_LSB +: 5];
  assign b_sel     = cw[CW_BSEL];
  assign wb_sel    = cw[CW_WBSEL];
  assign set_flags = cw[CW_SETFLAGS];

  // Stage-M state
  logic [DATA_WIDTH-1:0] m_alu, m_store;
  m_ctrl_t               m_ctrl;

  // Data memory (not reset)
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [MA_W-1:0]       mem_addr;
  logic                  mem_we, rf_we;

  // Stage E operands and ALU
  logic [DATA_WIDTH-1:0] rd_a, rd_b, op_a, b_reg, op_b;
  logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [DATA_WIDTH:0]   sum;
  logic                  flag_c, flag_v;

  assign mem_addr = m_alu[MA_W-1:0];
  assign mem_we   = wb_valid && !hold && !reset && m_ctrl.mem_write;
  assign rf_we    = wb_valid && !hold && m_ctrl.reg_write;

  regfile_legv8_param #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_regfile (
    .clock (clock),
    .reset (reset),
    .ra_a  (sa),
    .ra_b  (sb),
    .rd_a  (rd_a),
    .rd_b  (rd_b),
    .we    (rf_we),
    .wa    (wb_reg),
    .wd    (wb_data)
  );

  // Write-back mux: a combined load/store sees memory before its own write
  always_comb begin
    wb_data = m_alu;
    if (m_ctrl.wb_sel) wb_data = mem[mem_addr];
    else               wb_data = m_alu;
  end

  // Operand fetch with forwarding from stage M (never for XZR)
  always_comb begin
    op_a  = rd_a;
    b_reg = rd_b;
    op_b  = rd_b;
    if (wb_valid && m_ctrl.reg_write && (wb_reg == sa) && (sa != XZR)) op_a = wb_data;
    else                                                              op_a = rd_a;
    if (wb_valid && m_ctrl.reg_write && (wb_reg == sb) && (sb != XZR)) b_reg = wb_data;
    else                                                              b_reg = rd_b;
    if (b_sel) op_b = constant;
    else       op_b = b_reg;
  end

  // ALU: FS[1] inverts A, FS[0] inverts B and supplies the adder carry-in
  always_comb begin
    alu_a      = op_a;
    alu_b      = op_b;
    alu_result = '0;
    flag_c     = 1'b0;
    flag_v     = 1'b0;
    if (fs[1]) alu_a = ~op_a;
    else       alu_a = op_a;
    if (fs[0]) alu_b = ~op_b;
    else       alu_b = op_b;
    sum = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_WIDTH{1'b0}}, fs[0]};
    case (fs[4:2])
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_ADD: begin
        alu_result = sum[DATA_WIDTH-1:0];
        flag_c     = sum[DATA_WIDTH];
        // Overflow: operands agree in sign, result does not
        flag_v     = (alu_a[DATA_WIDTH-1] == alu_b[DATA_WIDTH-1]) &&
                     (sum[DATA_WIDTH-1] != alu_a[DATA_WIDTH-1]);
      end
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_LSL: alu_result = alu_a << alu_b[SH_W-1:0];
      ALU_LSR: alu_result = alu_a >> alu_b[SH_W-1:0];
      default: alu_result = '0;
    endcase
  end

  // Stage-M capture, bubble insertion and flag register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_alu    <= '0;
      m_store  <= '0;
      wb_reg   <= '0;
      m_ctrl   <= '0;
      wb_valid <= 1'b0;
      status   <= 4'b0000;
    end else if (!hold) begin
      if (cw_valid) begin
        m_alu            <= alu_result;
        m_store          <= b_reg;
        wb_reg           <= da;
        m_ctrl.reg_write <= reg_write;
        m_ctrl.mem_write <= mem_write;
        m_ctrl.wb_sel    <= wb_sel;
        wb_valid         <= 1'b1;
        if (set_flags) begin
          status <= {flag_v, flag_c, alu_result[DATA_WIDTH-1], (alu_result == '0)};
        end
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

  // Data-memory write at the end of stage M
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= m_store;
    end
  end

endmodule
